stream_fifo: RTL
================

# stream_fifo

Parametrised synchronous FIFO for the UART stdin/stdout buffering paths: the UART controller pushes received bytes for the core, and the core pushes stdout bytes for the UART to drain. Width and depth are configurable, and an occupancy count, an almost-full threshold, a synchronous flush and sticky overflow/underflow flags are provided. Read timing is selected at compile time: registered read (block-RAM friendly) or first-word-fall-through.

## Interface
- `WIDTH`, default 8: data word width in bits, ≥1.
- `DEPTH`, default 16: number of entries, power of two, ≥2.
- `ALMOST_FULL_LEVEL`, default `DEPTH-2`: `almost_full` asserts when `count ≥` this value; legal range 1..`DEPTH`.
- `clk`  in  1  sole clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `flush`  in  1  synchronous clear of contents and flags.
- `write_enable`  in  1  push request.
- `write_data`  in  `WIDTH`  push data.
- `read_enable`  in  1  pop request.
- `read_data`  out  `WIDTH`  popped or head data (see Configuration).
- `read_ready`  out  1  FIFO non-empty; pop will be accepted.
- `write_ready`  out  1  FIFO not full; push will be accepted.
- `count`  out  `$clog2(DEPTH)+1`  current occupancy, 0..`DEPTH`.
- `almost_full`  out  1  `count ≥ ALMOST_FULL_LEVEL`.
- `overflow`  out  1  sticky: a push was attempted while full.
- `underflow`  out  1  sticky: a pop was attempted while empty.

## Operation
- Storage: `DEPTH` × `WIDTH` array; read/write pointers of `$clog2(DEPTH)` bits; pointers wrap naturally from `DEPTH-1` to 0.
- Occupancy is an explicit `count` register; full is `count==DEPTH`, empty is `count==0`.
- Push is accepted iff `write_enable && write_ready`. It writes `write_data` at the write pointer and increments that pointer.
- Pop is accepted iff `read_enable && read_ready`. It increments the read pointer.
- `count` update on accepted operations: push only +1; pop only −1; both 0.
- Simultaneous push and pop while empty: only the push is accepted (`read_ready=0`) and `underflow` sets.
- Simultaneous push and pop while full: only the pop is accepted (`write_ready=0`) and `overflow` sets. No pass-through at full.
- Rejected push: array, pointers and `count` are unchanged; `overflow` ← 1.
- Rejected pop: array, pointers and `count` are unchanged; `read_data` holds; `underflow` ← 1.
- `flush`: pointers, `count`, `overflow` and `underflow` go to 0 on the next edge. It overrides any push or pop in the same cycle, which are discarded and do not set flags. Array contents are not cleared. `read_data` holds in registered mode.
- Outputs `read_ready`, `write_ready` and `almost_full` are decoded from registered `count` only. They do not depend combinationally on `read_enable` or `write_enable`.

## Timing
- Reset values (async assert): `count=0`, pointers 0, `read_ready=0`, `write_ready=1`, `almost_full=0`, `overflow=0`, `underflow=0`, `read_data=0`.
- Reset mid-operation discards all contents immediately. Deassertion is released on the next `clk` edge.
- Push-to-visible latency: `read_ready` rises the cycle after the first accepted push into an empty FIFO.
- `count`, flags and pointers update on the same edge that accepts the operation.
- Registered read: `read_data` is valid the cycle after an accepted pop and holds until the next accepted pop.
- Sticky flags set on the edge after the offending request and stay set until `flush` or reset.

## Configuration
- Macro: `STREAM_FIFO_FWFT_EN`.
- Defined (first-word-fall-through): `read_data` combinationally presents the entry at the read pointer whenever `read_ready=1`. An accepted pop advances to the next entry on the following edge. `read_data` is undefined (array content) when empty.
- Not defined (registered read): `read_data` is a register loaded from the array on accepted pop (1-cycle latency). It is reset to 0 and is block-RAM inferable.

## Test plan
- Fill/drain (`WIDTH=8`, `DEPTH=4`): push 0x11, 0x22, 0x33, 0x44 → `count` goes 1..4, `write_ready=0` after the 4th, `almost_full=1` from `count=2`. Pop ×4 → data 0x11..0x44 in order, `read_ready=0` at end.
- Wrap-around: push 3 words, pop 2, push 3, pop 4 → order preserved across the pointer wrap, final `count=0`.
- Boundaries: push at full → `overflow=1`, `count` stays 4, contents intact. Pop at empty → `underflow=1`, `count` stays 0. Simultaneous push+pop at `count=2` → `count` stays 2, FIFO order preserved.
- Flush: with `count=3` and `overflow=1`, assert `flush` with `write_enable=1` → next cycle `count=0`, `overflow=0`, `read_ready=0`, pushed word discarded.
- Reset mid-stream: assert `reset_n=0` asynchronously between edges with `count=2` → outputs take their reset values immediately, without waiting for a clock edge.
- Read mode: run fill/drain in both builds. FWFT: 0x11 is on `read_data` in the cycle `read_ready` rises. Registered: 0x11 appears one cycle after the first accepted pop.

Source files
------------

// File: rtl/stream_fifo_if.sv
// stream_fifo_if: push/pop handshake, flush and status bundle shared by a FIFO and its user
interface stream_fifo_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
);
  localparam int CW = $clog2(DEPTH) + 1;
  logic             flush;
  logic             write_enable;
  logic [WIDTH-1:0] write_data;
  logic             read_enable;
  logic [WIDTH-1:0] read_data;
  logic             read_ready;
  logic             write_ready;
  logic [CW-1:0]    count;
  logic             almost_full;
  logic             overflow;
  logic             underflow;
  modport master (
    output flush, write_enable, write_data, read_enable,
    input  read_data, read_ready, write_ready, count, almost_full, overflow, underflow
  );
  modport slave (
    input  flush, write_enable, write_data, read_enable,
    output read_data, read_ready, write_ready, count, almost_full, overflow, underflow
  );
endinterface

// File: rtl/stream_fifo.sv
// stream_fifo: synchronous FIFO with occupancy count, almost-full, flush and sticky flags; define STREAM_FIFO_FWFT_EN for first-word-fall-through read, otherwise registered read
module stream_fifo #(
  parameter int WIDTH             = 8,
  parameter int DEPTH             = 16,
  parameter int ALMOST_FULL_LEVEL = DEPTH - 2
) (
  input logic         clk,
  input logic         reset_n,
  stream_fifo_if.slave s_fifo
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic             r_overflow;
  logic             r_underflow;
  logic [CW-1:0]    w_count_nxt;
  logic             w_rd_ready;
  logic             w_wr_ready;
  logic             w_push;
  logic             w_pop;
  // handshake readiness is decoded from the registered count only
  assign w_rd_ready = r_count != '0;
  assign w_wr_ready = r_count != CW'(DEPTH);
  assign w_push     = s_fifo.write_enable && w_wr_ready;
  assign w_pop      = s_fifo.read_enable && w_rd_ready;
  // occupancy moves only when exactly one side is accepted
  always_comb begin
    w_count_nxt = (w_push && !w_pop) ? r_count + 1'b1 :
                  (w_pop && !w_push) ? r_count - 1'b1 : r_count;
  end
  // pointers, count and sticky flags; flush wins over any same-cycle request
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (s_fifo.flush) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      r_count <= w_count_nxt;
      if (s_fifo.write_enable && !w_wr_ready) r_overflow <= 1'b1;
      if (s_fifo.read_enable && !w_rd_ready) r_underflow <= 1'b1;
    end
  end
  // storage array is left unreset so it can map onto block RAM
  always_ff @(posedge clk) begin
    if (w_push && !s_fifo.flush) r_mem[r_wptr] <= s_fifo.write_data;
  end
`ifdef STREAM_FIFO_FWFT_EN
  assign s_fifo.read_data = r_mem[r_rptr];
`else
  logic [WIDTH-1:0] r_read_data;
  // registered read: load the head on an accepted pop, hold otherwise
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_read_data <= '0;
    else if (w_pop && !s_fifo.flush) r_read_data <= r_mem[r_rptr];
  end
  assign s_fifo.read_data = r_read_data;
`endif
  assign s_fifo.read_ready  = w_rd_ready;
  assign s_fifo.write_ready = w_wr_ready;
  assign s_fifo.count       = r_count;
  assign s_fifo.almost_full = r_count >= CW'(ALMOST_FULL_LEVEL);
  assign s_fifo.overflow    = r_overflow;
  assign s_fifo.underflow   = r_underflow;
endmodule
